hamming_stream_acc: RTL and testbench

Sequential, chunked front end for Hamming-distance evaluation. Accepts operand pair x/y as a stream of W-bit chunks over valid/ready, accumulates popcount(x^y) per chunk, and presents one N-bit distance per vector on an output valid/ready port. Trades the fully combinational N-bit popcount for a W-bit popcount per cycle; sits between the operand source (garbled-circuit input loader) and the distance consumer.

---
 rtl/hamming_stream_acc_pkg.sv | 31 +++
 rtl/hamming_stream_acc_popcount.sv | 19 +
 rtl/hamming_stream_acc.sv | 93 +++++++++
 tb/tb_hamming_stream_acc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_stream_acc_pkg.sv
// Shared definitions for the hamming block family: width helpers and FSM encoding.
package hamming_stream_acc_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Bits needed to hold v, i.e. floor(log2(v)) + 1; matches the other hamming blocks.
    function automatic int hs_log2(input int v);
        int r;
        int t;
        r = 0;
        t = v;
        while (t > 0) begin
            r = r + 1;
            t = t >>> 1;
        end
        return r;
    endfunction

    function automatic int hs_chunks(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    // Number of meaningful bits carried by the final chunk of a vector.
    function automatic int hs_last_bits(input int n, input int w);
        return n - (hs_chunks(n, w) - 1) * w;
    endfunction

endpackage

// File: rtl/hamming_stream_acc_popcount.sv
// Combinational population count of a W-bit word; shared by the hamming variants.
module hamming_popcount
    import hamming_stream_acc_pkg::*;
#(
    parameter  int W  = 64,
    localparam int CW = hs_log2(W)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(d[i]);
        end
    end

endmodule

// File: rtl/hamming_stream_acc.sv
// Chunked Hamming distance: accumulates popcount(x^y) over CHUNKS W-bit beats, then
// holds the N-bit distance on o until the consumer takes it; no input accepted while holding.
module hamming_stream_acc
    import hamming_stream_acc_pkg::*;
#(
    parameter  int N  = 1600,
    parameter  int W  = 64,
    localparam int DW = hs_log2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_chunk,
    input  logic [W-1:0]  y_chunk,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] o
);

    localparam int CHUNKS    = hs_chunks(N, W);
    localparam int CW        = hs_log2(W);
    localparam int LAST_BITS = hs_last_bits(N, W);
    localparam int IW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [W-1:0] LAST_MASK = {W{1'b1}} >> (W - LAST_BITS);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] acc;
    logic [IW-1:0] idx;
    logic          is_last;
    logic          accept;
    logic [W-1:0]  diff;
    logic [CW-1:0] pc;
    logic [DW-1:0] sum;

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign is_last   = (idx == IW'(CHUNKS - 1));

    // Padding bits beyond N in the final chunk must not count toward the distance.
    assign diff = (x_chunk ^ y_chunk) & (is_last ? LAST_MASK : {W{1'b1}});
    assign sum  = acc + DW'(pc);

    hamming_popcount #(.W(W)) u_popcount (
        .d   (diff),
        .cnt (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (accept && is_last) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)         state_nxt = ST_ACC;
            default:                        state_nxt = ST_ACC;
        endcase
        if (clr) begin
            state_nxt = ST_ACC;
        end
    end

    // clr outranks any handshake; o deliberately survives clr so the last result stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
            o   <= '0;
        end else if (clr) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            if (is_last) begin
                o   <= sum;
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= sum;
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_stream_acc.sv
// Randomized scoreboard bench: full-vector reference distances vs. streamed DUT results.
module tb_hamming_stream_acc;

    localparam int N  = 1600;
    localparam int NC = 25;
    localparam logic [127:0] SMASK = (128'd1 << 100) - 128'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] x_chunk = '0;
    logic [63:0] y_chunk = '0;
    logic        in_ready;
    logic        out_valid;
    logic [10:0] o;

    logic        s_clr = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_out_ready = 1'b1;
    logic [63:0] s_x = '0;
    logic [63:0] s_y = '0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [6:0]  s_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int s_exp_q[$];
    bit rdy_force = 1'b1;
    bit rdy_val   = 1'b0;

    hamming_stream_acc #(.N(1600), .W(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .x_chunk(x_chunk), .y_chunk(y_chunk), .out_valid(out_valid), .out_ready(out_ready), .o(o)
    );

    hamming_stream_acc #(.N(100), .W(64)) u_small (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x_chunk(s_x), .y_chunk(s_y), .out_valid(s_out_valid), .out_ready(s_out_ready), .o(s_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: either pinned by the test or random, applied at posedge+2.
    always begin
        @(posedge clk);
        #2;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    // Monitors: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (out_valid && clr) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_result: got %0d, expected none", o);
            end else begin
                check("distance", int'(o), exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            if (s_exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_small_result: got %0d, expected none", s_o);
            end else begin
                check("small_distance", int'(s_o), s_exp_q.pop_front());
            end
        end
    end

    // All drive tasks start and end at posedge+1.
    task automatic send_chunk(input logic [63:0] xc, input logic [63:0] yc, input int max_gap);
        int  g;
        bit  acc_now;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1; x_chunk = xc; y_chunk = yc;
        for (int t = 0; ; t++) begin
            @(negedge clk); acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) break;
            if (t > 300) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: got no in_ready, expected acceptance");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [N-1:0] xv, input logic [N-1:0] yv, input int max_gap, input int nch);
        for (int k = 0; k < nch; k++) send_chunk(xv[k*64 +: 64], yv[k*64 +: 64], max_gap);
        if (nch == NC) exp_q.push_back($countones(xv ^ yv));
    endtask

    task automatic s_send(input logic [127:0] xr, input logic [127:0] yr, input int exp);
        bit acc_now;
        for (int k = 0; k < 2; k++) begin
            s_in_valid = 1'b1; s_x = xr[k*64 +: 64]; s_y = yr[k*64 +: 64];
            for (int t = 0; ; t++) begin
                @(negedge clk); acc_now = s_in_ready;
                @(posedge clk); #1;
                if (acc_now) break;
                if (t > 300) begin
                    n_tests++; n_fail++;
                    $display("FAIL small_accept_timeout: got no in_ready, expected acceptance");
                    break;
                end
            end
            s_in_valid = 1'b0;
        end
        s_exp_q.push_back(exp);
    endtask

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    task automatic drain();
        for (int t = 0; t < 3000 && (exp_q.size() != 0 || s_exp_q.size() != 0); t++) @(posedge clk);
        @(posedge clk); #1;
        check("drain_pending", exp_q.size() + s_exp_q.size(), 0);
    endtask

    initial begin
        logic [N-1:0] xv, yv;
        logic [127:0] xr, yr;
        int e;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_o", int'(o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_small_in_ready", int'(s_in_ready), 1);
        @(posedge clk); #1;

        // Zero vectors: result must appear the cycle after the final accept.
        send_vec('0, '0, 0, NC);
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
        check("latency_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rdy_val = 1'b1;
        rdy_force = 1'b0;

        send_vec({N{1'b1}}, '0, 3, NC);

        s_send({64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, 128'h0, 37);

        for (int v = 0; v < 15; v++) send_vec(rand_vec(), rand_vec(), 2, NC);
        for (int v = 0; v < 10; v++) begin
            xr = {$urandom, $urandom, $urandom, $urandom};
            yr = {$urandom, $urandom, $urandom, $urandom};
            s_send(xr, yr, $countones((xr ^ yr) & SMASK));
        end
        drain();

        // Backpressure: held result must not move and no chunk may be taken.
        rdy_force = 1'b1; rdy_val = 1'b0;
        xv = rand_vec(); yv = rand_vec(); e = $countones(xv ^ yv);
        send_vec(xv, yv, 0, NC);
        in_valid = 1'b1; x_chunk = $urandom; y_chunk = $urandom;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_o", int'(o), e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_val = 1'b1;
        send_vec(rand_vec(), rand_vec(), 1, NC);
        drain();

        // Abort after 10 chunks, then a vector differing only in its top bit.
        send_vec(rand_vec(), rand_vec(), 1, 10);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        yv = '0; yv[N-1] = 1'b1;
        send_vec('0, yv, 0, NC);
        drain();

        // clr coincident with the output handshake drops the result but keeps o.
        rdy_val = 1'b0;
        xv = rand_vec(); yv = rand_vec(); e = $countones(xv ^ yv);
        send_vec(xv, yv, 0, NC);
        clr = 1'b1; rdy_val = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; rdy_val = 1'b0;
        @(negedge clk);
        check("clr_drop_out_valid", int'(out_valid), 0);
        check("clr_keeps_o", int'(o), e);
        check("clr_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rdy_force = 1'b0;
        drain();

        // Asynchronous reset in the middle of a vector.
        send_vec(rand_vec(), rand_vec(), 0, 12);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_o", int'(o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_vec({N{1'b1}}, '0, 1, NC);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
